// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, RV32I width codes,
// and the request legality/alignment checks.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes the access size for every legal code: 00 byte, 01 half, 10 word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_illegal(input logic store, input logic [2:0] funct3);
        if (store) begin
            return funct3 > F3_W;
        end
        return (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

    function automatic logic [1:0] align_lo(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b01:   return {addr_lo[1], 1'b0};
            2'b10:   return 2'b00;
            default: return addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
interface lsu_if #(
    parameter int unsigned D_WIDTH = 32
);
    logic               req;
    logic               store;
    logic [2:0]         funct3;
    logic [31:0]        addr;
    logic [D_WIDTH-1:0] wdata;
    logic               ready;
    logic               valid;
    logic               err;
    logic [D_WIDTH-1:0] rdata;

    modport master (
        output req, store, funct3, addr, wdata,
        input  ready, valid, err, rdata
    );

    modport slave (
        input  req, store, funct3, addr, wdata,
        output ready, valid, err, rdata
    );
endinterface

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: little-endian load extraction/extension and
// sub-word store merge into a previously read memory word.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rd_word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] ld_data_c_o,
    output logic [31:0] st_word_c_o
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    assign byte_c = rd_word_i[{addr_lo_i, 3'b000} +: 8];
    assign half_c = addr_lo_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];

    always_comb begin
        ld_data_c_o = rd_word_i;
        case (funct3_i)
            F3_B:    ld_data_c_o = {{24{byte_c[7]}}, byte_c};
            F3_BU:   ld_data_c_o = {24'h000000, byte_c};
            F3_H:    ld_data_c_o = {{16{half_c[15]}}, half_c};
            F3_HU:   ld_data_c_o = {16'h0000, half_c};
            default: ld_data_c_o = rd_word_i;
        endcase
    end

    // Only the addressed lane(s) take store data; the rest keep the read word.
    always_comb begin
        st_word_c_o = rd_word_i;
        case (funct3_i)
            F3_B: st_word_c_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H: begin
                if (addr_lo_i[1]) begin
                    st_word_c_o[31:16] = wdata_i[15:0];
                end else begin
                    st_word_c_o[15:0] = wdata_i[15:0];
                end
            end
            default: st_word_c_o = rd_word_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: maps byte/half/word accesses onto a word-only memory, sub-word
// stores via read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned A_WIDTH = 20,
    parameter int unsigned D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    lsu_if.slave               bus,
    output logic [A_WIDTH-1:0] mem_a_o,
    output logic [D_WIDTH-1:0] mem_wd_o,
    output logic               mem_we_o,
    input  logic [D_WIDTH-1:0] mem_rd_i
);

    localparam int unsigned BA_WIDTH = A_WIDTH + 2;

    lsu_state_t            state_q, state_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [BA_WIDTH-1:0]   addr_q, addr_d;
    logic [D_WIDTH-1:0]    wd_q, wd_d;
    logic [D_WIDTH-1:0]    rdata_q, rdata_d;
    logic                  acc_err_q, acc_err_d;
    logic                  ready_q, ready_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;

    logic                  req_illegal_c;
    logic                  req_err_c;
    logic [BA_WIDTH-1:0]   req_addr_c;
    logic [D_WIDTH-1:0]    ld_data_c;
    logic [D_WIDTH-1:0]    st_word_c;
    logic                  unused_addr_c;

    assign unused_addr_c = ^bus.addr[31:BA_WIDTH];
    assign req_illegal_c = is_illegal(bus.store, bus.funct3);

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_err_c  = req_illegal_c | is_misaligned(bus.funct3, bus.addr[1:0]);
    assign req_addr_c = bus.addr[BA_WIDTH-1:0];
`else
    // Misaligned accesses are silently rounded down to natural alignment.
    assign req_err_c  = req_illegal_c;
    assign req_addr_c = {bus.addr[BA_WIDTH-1:2], align_lo(bus.funct3, bus.addr[1:0])};
`endif

    lsu_lane u_lane (
        .funct3_i    (funct3_q),
        .addr_lo_i   (addr_q[1:0]),
        .rd_word_i   (mem_rd_i),
        .wdata_i     (wd_q),
        .ld_data_c_o (ld_data_c),
        .st_word_c_o (st_word_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            funct3_q  <= 3'b000;
            addr_q    <= '0;
            wd_q      <= '0;
            rdata_q   <= '0;
            acc_err_q <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            rdata_q   <= rdata_d;
            acc_err_q <= acc_err_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            we_q      <= we_d;
        end
    end

    // wd_q holds store data after capture and is overwritten by the merged word in RMW_RD.
    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        rdata_d   = rdata_q;
        acc_err_d = acc_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    funct3_d  = bus.funct3;
                    addr_d    = req_addr_c;
                    wd_d      = bus.wdata;
                    acc_err_d = req_err_c;
                    if (req_err_c) begin
                        state_d = S_DONE;
                    end else if (!bus.store) begin
                        state_d = S_LOAD;
                    end else if (bus.funct3 == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                rdata_d = ld_data_c;
                state_d = S_DONE;
            end
            S_RMW_RD: begin
                wd_d    = st_word_c;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        valid_d = (state_d == S_DONE);
        err_d   = (state_d == S_DONE) && acc_err_d;
        we_d    = (state_d == S_WRITE);
    end

    assign bus.ready = ready_q;
    assign bus.valid = valid_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign mem_a_o   = addr_q[BA_WIDTH-1:2];
    assign mem_wd_o  = wd_q;
    assign mem_we_o  = we_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

- Sits between the execute stage and the word-addressed data memory.
- Turns byte/halfword/word loads and stores from the core into whole-word memory accesses.
- Sub-word stores use a read-modify-write sequence, because the memory only writes whole words.
- Loads are sign- or zero-extended.
- Misaligned accesses are detected.
- Multi-cycle, one request in flight, simple REQ/READY/VALID handshake.

## Interface

Parameters:
- A_WIDTH, 20: memory word-address width; byte address bits [A_WIDTH+1:2] select the word.
- D_WIDTH, 32: data width; fixed at 32 for byte-lane logic.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- REQ  in  1  request; sampled only when READY=1.
- STORE  in  1  1 = store, 0 = load.
- FUNCT3  in  3  RV32I width code: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW.
- ADDR  in  32  byte address.
- WDATA  in  D_WIDTH  store data, right-aligned.
- READY  out  1  1 only in IDLE.
- VALID  out  1  one-cycle completion pulse.
- ERR  out  1  qualifies VALID: access was misaligned or had an illegal FUNCT3.
- RDATA  out  D_WIDTH  extended load result; held until the next load completes.
- MEM_A  out  A_WIDTH  word address to memory.
- MEM_WD  out  D_WIDTH  write word to memory.
- MEM_WE  out  1  memory write enable.
- MEM_RD  in  D_WIDTH  memory read word; combinational with MEM_A.

## Operation

- States:
  - IDLE
  - LOAD
  - RMW_RD
  - WRITE
  - DONE
- Request capture:
  - In IDLE with REQ=1, latch STORE, FUNCT3, ADDR, WDATA.
  - REQ in any other state is ignored.
- Transitions out of IDLE:
  - Load → LOAD.
  - SW → WRITE.
  - SB/SH → RMW_RD.
  - Illegal or misaligned → DONE with ERR.
- Transitions out of the other states:
  - LOAD → DONE. Select the byte lane(s) by latched ADDR[1:0] (little-endian), extend per FUNCT3, register into RDATA.
  - RMW_RD → WRITE. Register MEM_RD into the merge word; replace the target lane(s) with the low byte/halfword of latched WDATA.
  - WRITE → DONE. MEM_WE=1 and MEM_WD = merged word (SB/SH) or latched WDATA (SW).
  - DONE → IDLE. VALID=1 and ERR per the check.
- Alignment rules:
  - LH/LHU/SH misaligned when ADDR[0]=1.
  - LW/SW misaligned when ADDR[1:0]≠00.
  - Byte accesses are never misaligned.
  - Illegal FUNCT3: 011, 110 and 111 for loads; anything above 010 for stores.
- Errored accesses:
  - No memory write.
  - RDATA unchanged.
- Address mapping:
  - MEM_A = latched ADDR[A_WIDTH+1:2].
  - Higher address bits are ignored (wrap-around).
  - MEM_A is driven in every state.
- MEM_WE is a combinational decode of state: 1 only in WRITE.

## Timing

- Cycle 0 is the edge at which REQ is sampled in IDLE.
- Latency from that edge to VALID high:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- READY is low from cycle 1 through DONE and returns high the cycle after VALID.
- Minimum back-to-back spacing:
  - Loads and SW: one request every 3 cycles.
  - SB/SH: one request every 4 cycles.
- Reset values:
  - State IDLE, so READY=1.
  - VALID=0, ERR=0, RDATA=0, MEM_WE=0.
  - Latched ADDR=0, so MEM_A=0; MEM_WD=0.
- Reset asserted mid-operation:
  - Returns to IDLE immediately.
  - MEM_WE drops combinationally, so no write occurs at any edge while RST_N=0.
  - A partially completed RMW is abandoned and memory is unchanged.
  - No VALID is issued for the aborted access.

## Configuration

- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned accesses raise ERR as described above.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misaligned accesses are forced to natural alignment (LH/LHU/SH clear ADDR[0]; LW/SW clear ADDR[1:0]).
  - They are then performed normally.
  - ERR asserts only for illegal FUNCT3.

## Structure

- lsu_pkg holds:
  - State enum lsu_state_t.
  - FUNCT3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - Function is_misaligned(funct3, addr_lo).
- Sub-module lsu_lane (combinational) performs:
  - Load lane extraction and extension.
  - Store lane merge.
- The FSM and all registers stay in load_store_unit.

## Test plan

- Reset, then LW at ADDR 0x10 with memory word 4 = 0x8899AABB:
  - VALID at cycle 2.
  - RDATA=0x8899AABB, ERR=0, MEM_WE never high.
- LB at ADDR 0x13 with word 0x80112233:
  - RDATA=0xFFFFFF80.
  - LBU at the same address gives 0x00000080.
  - LH at 0x12 gives 0xFFFF8011.
- SB of WDATA 0x000000EE at ADDR 0x21 with word 8 = 0x11223344:
  - MEM_WE high exactly one cycle, in cycle 2, with MEM_WD=0x1122EE44.
  - VALID at cycle 3.
- LW at ADDR 0x02 with LSU_MISALIGN_TRAP_EN defined:
  - VALID and ERR at cycle 1, RDATA unchanged.
  - With the macro undefined, word 0 is returned and ERR=0.
- SH at 0x40 with RST_N pulled low during RMW_RD:
  - No MEM_WE pulse, memory word 16 unchanged.
  - READY=1 after release.
- REQ held high continuously with alternating LW/SW:
  - Each accepted only in IDLE.
  - VALID spacing is exactly 3 cycles.
  - No request is dropped or duplicated.
